// File: rtl/stb_dcache_arbiter.sv
// Shares the single dcache port between LSU loads and store-buffer drains.
// Loads win by default; starvation, a full store buffer or a fence force stores through.
module stb_dcache_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsu_req,
  input  logic [ADDR_W-1:0]   lsu_addr,
  output logic                lsu_ack,
  output logic [DATA_W-1:0]   lsu_rdata,
  input  logic                stb_req,
  input  logic [ADDR_W-1:0]   stb_addr,
  input  logic [DATA_W-1:0]   stb_wdata,
  input  logic [DATA_W/8-1:0] stb_sel,
  input  logic                stb_full,
  input  logic                stb_empty,
  output logic                stb_ack,
  input  logic                fence_req,
  output logic                fence_done,
  output logic                dcache_req,
  output logic                dcache_we,
  output logic [ADDR_W-1:0]   dcache_addr,
  output logic [DATA_W-1:0]   dcache_wdata,
  output logic [DATA_W/8-1:0] dcache_sel,
  input  logic                dcache_ack,
  input  logic [DATA_W-1:0]   dcache_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FENCE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             arb_en;
  logic             in_fence;
  logic             fence_store;

  assign in_fence    = (state == FENCE);
  assign fence_store = in_fence & stb_req;
  assign arb_en      = (state == IDLE) | (((state == LOAD) | (state == STORE)) & dcache_ack);

  // A store acked this cycle is still outstanding, so the drain completes one cycle later.
  assign fence_done  = in_fence & stb_empty & ~stb_req & ~dcache_ack;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    if (in_fence) begin
      starve_nxt = '0;
      if (fence_done) state_nxt = IDLE;
    end else if (arb_en) begin
      if (fence_req) begin
        state_nxt  = FENCE;
        starve_nxt = '0;
      end else if (stb_req & (stb_full | (starve_cnt == STARVE_LIM))) begin
        state_nxt  = STORE;
        starve_nxt = '0;
      end else if (lsu_req) begin
        state_nxt = LOAD;
        // Reaching here with stb_req set implies starve_cnt < STARVE_LIM, so this saturates.
        if (stb_req) starve_nxt = starve_cnt + CNT_W'(1);
      end else if (stb_req) begin
        state_nxt  = STORE;
        starve_nxt = '0;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    dcache_req   = 1'b0;
    dcache_we    = 1'b0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    dcache_sel   = '0;
    if (state == LOAD) begin
      dcache_req  = 1'b1;
      dcache_addr = lsu_addr;
      dcache_sel  = '1;
    end else if ((state == STORE) | fence_store) begin
      dcache_req   = 1'b1;
      dcache_we    = 1'b1;
      dcache_addr  = stb_addr;
      dcache_wdata = stb_wdata;
      dcache_sel   = stb_sel;
    end
  end

  assign lsu_ack   = (state == LOAD) & dcache_ack;
  assign stb_ack   = ((state == STORE) | in_fence) & dcache_ack;
  assign lsu_rdata = lsu_ack ? dcache_rdata : '0;

endmodule
